// File: rtl/uart_shift_transceiver_if.sv
// Host-side bundle for uart_shift_transceiver: transmit strobe/busy,
// receive ready/clear handshake and the received-byte accumulator.
interface uart_shift_transceiver_if #(
  parameter int unsigned DATA_WIDTH = 640
);
  logic [7:0]            din;
  logic                  wr_en;
  logic                  tx_busy;
  logic                  rdy;
  logic                  rdy_clr;
  logic [7:0]            dout;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  acc_clr;

  modport master (
    output din, wr_en, rdy_clr, acc_clr,
    input  tx_busy, rdy, dout, acc_data
  );

  modport slave (
    input  din, wr_en, rdy_clr, acc_clr,
    output tx_busy, rdy, dout, acc_data
  );
endinterface

// File: rtl/uart_shift_transceiver.sv
// 8N1 UART transceiver. Valid received bytes are delivered on a ready/clear
// handshake and shifted into a wide accumulator (newest byte in [7:0]).
module uart_shift_transceiver #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_WIDTH = 640
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx,
  output logic                    tx,
  uart_shift_transceiver_if.slave bus
);

  localparam int unsigned BIT_CYC  = CLK_HZ / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  logic [1:0]       tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]       tx_bit_q,   tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q,       tx_d;
  logic             tx_busy_q,  tx_busy_d;
  logic             tx_wrap_c;

  assign tx_wrap_c = (tx_cnt_q == CNT_W'(BIT_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // Line level and busy are computed one cycle ahead so both leave a flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;

    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (bus.wr_en && !tx_busy_q) begin
          tx_state_d = START;
          tx_shift_d = bus.din;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      START: begin
        tx_cnt_d = tx_wrap_c ? '0 : tx_cnt_q + CNT_W'(1);
        if (tx_wrap_c) begin
          tx_state_d = DATA;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end
      end
      DATA: begin
        tx_cnt_d = tx_wrap_c ? '0 : tx_cnt_q + CNT_W'(1);
        if (tx_wrap_c) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_d     = tx_shift_q[1];
          end
        end
      end
      STOP: begin
        tx_cnt_d = tx_wrap_c ? '0 : tx_cnt_q + CNT_W'(1);
        if (tx_wrap_c) begin
          tx_state_d = IDLE;
          tx_busy_d  = 1'b0;
        end
      end
    endcase
  end

  assign tx          = tx_q;
  assign bus.tx_busy = tx_busy_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic                  rx_s1_q, rx_s2_q;
  logic [1:0]            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]      rx_cnt_q,   rx_cnt_d;
  logic [2:0]            rx_bit_q,   rx_bit_d;
  logic [7:0]            rx_shift_q, rx_shift_d;
  logic                  rdy_q,      rdy_d;
  logic [7:0]            dout_q,     dout_d;
  logic [DATA_WIDTH-1:0] acc_q,      acc_d;
  logic                  rx_half_c, rx_wrap_c, rx_done_c;

  assign rx_half_c = (rx_cnt_q == CNT_W'(HALF_CYC - 1));
  assign rx_wrap_c = (rx_cnt_q == CNT_W'(BIT_CYC - 1));

  // Two-flop synchronizer resets to the idle line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rdy_q      <= 1'b0;
      dout_q     <= '0;
      acc_q      <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rdy_q      <= rdy_d;
      dout_q     <= dout_d;
      acc_q      <= acc_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done_c  = 1'b0;

    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) begin
          rx_state_d = START;
        end
      end
      // Mid-start-bit check: a line already back high was only a glitch.
      START: begin
        rx_cnt_d = rx_half_c ? '0 : rx_cnt_q + CNT_W'(1);
        if (rx_half_c) begin
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        rx_cnt_d = rx_wrap_c ? '0 : rx_cnt_q + CNT_W'(1);
        if (rx_wrap_c) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        rx_cnt_d = rx_wrap_c ? '0 : rx_cnt_q + CNT_W'(1);
        if (rx_wrap_c) begin
          rx_state_d = IDLE;
          rx_done_c  = rx_s2_q;
        end
      end
    endcase
  end

  // A completing byte beats rdy_clr; acc_clr beats a completing byte.
  always_comb begin
    rdy_d  = rx_done_c | (rdy_q & ~bus.rdy_clr);
    dout_d = rx_done_c ? rx_shift_q : dout_q;
    if (bus.acc_clr) begin
      acc_d = '0;
    end else if (rx_done_c) begin
      acc_d = {acc_q[DATA_WIDTH-9:0], rx_shift_q};
    end else begin
      acc_d = acc_q;
    end
  end

  assign bus.rdy      = rdy_q;
  assign bus.dout     = dout_q;
  assign bus.acc_data = acc_q;

endmodule

// File: tb/tb_uart_shift_transceiver.sv
// Directed + randomized bench for uart_shift_transceiver; expected values come
// from a byte-level model of the receive handshake and accumulator.
module tb_uart_shift_transceiver;
  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned BAUD    = 115200;
  localparam int unsigned DW      = 16;
  localparam int unsigned BIT_CYC = CLK_HZ / BAUD;

  logic clock = 1'b0;
  logic reset;
  logic rx_drv;
  logic loop_en;
  logic rx_line;
  logic tx;

  int errors = 0;
  int checks = 0;

  logic          m_rdy;
  logic [7:0]    m_dout;
  logic [DW-1:0] m_acc;
  logic [7:0]    rb;
  logic          rs;
  logic          rc0;
  logic          rc1;

  uart_shift_transceiver_if #(.DATA_WIDTH(DW)) bus ();

  assign rx_line = loop_en ? tx : rx_drv;

  uart_shift_transceiver #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_WIDTH(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx   (rx_line),
    .tx   (tx),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_rx_state(input string tag);
    chk({tag, "_rdy"},  64'(bus.rdy),      64'(m_rdy));
    chk({tag, "_dout"}, 64'(bus.dout),     64'(m_dout));
    chk({tag, "_acc"},  64'(bus.acc_data), 64'(m_acc));
  endtask

  // Drives one 8N1 frame on rx; optional clears coincide with the stop sample.
  task automatic send_rx(input logic [7:0] b, input logic stop, input logic clr_rdy,
                         input logic clr_acc, input string tag);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx_drv = frame[i];
      ticks(BIT_CYC);
    end
    rx_drv = stop;
    ticks(219);
    chk({tag, "_pre_rdy"},  64'(bus.rdy),  64'(m_rdy));
    chk({tag, "_pre_dout"}, 64'(bus.dout), 64'(m_dout));
    bus.rdy_clr = clr_rdy;
    bus.acc_clr = clr_acc;
    ticks(1);
    bus.rdy_clr = 1'b0;
    bus.acc_clr = 1'b0;
    if (stop) begin
      m_dout = b;
      m_rdy  = 1'b1;
    end else if (clr_rdy) begin
      m_rdy = 1'b0;
    end
    if (clr_acc) m_acc = '0;
    else if (stop) m_acc = DW'({m_acc, b});
    chk_rx_state(tag);
    ticks(BIT_CYC - 220);
    rx_drv = 1'b1;
    if (!stop) ticks(BIT_CYC);
  endtask

  // Requests one transmit and checks every bit boundary of the frame.
  task automatic send_tx(input logic [7:0] b, input logic inject, input string tag);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    bus.din   = b;
    bus.wr_en = 1'b1;
    ticks(1);
    bus.wr_en = 1'b0;
    bus.din   = 8'($urandom);
    chk({tag, "_busy_rise"}, 64'(bus.tx_busy), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_bit%0d_head", tag, i), 64'(tx), 64'(frame[i]));
      if (inject && i == 3) begin
        bus.din   = 8'hFF;
        bus.wr_en = 1'b1;
        ticks(1);
        bus.wr_en = 1'b0;
        ticks(BIT_CYC - 2);
      end else begin
        ticks(BIT_CYC - 1);
      end
      chk($sformatf("%s_bit%0d_tail", tag, i), 64'(tx), 64'(frame[i]));
      chk($sformatf("%s_bit%0d_busy", tag, i), 64'(bus.tx_busy), 64'd1);
      ticks(1);
    end
    chk({tag, "_busy_fall"}, 64'(bus.tx_busy), 64'd0);
    chk({tag, "_idle_line"}, 64'(tx), 64'd1);
    ticks(20);
    chk({tag, "_no_extra"}, 64'({bus.tx_busy, tx}), 64'b01);
  endtask

  task automatic clear_rdy(input string tag);
    bus.rdy_clr = 1'b1;
    ticks(1);
    bus.rdy_clr = 1'b0;
    m_rdy = 1'b0;
    chk({tag, "_rdy_clr"}, 64'(bus.rdy), 64'd0);
  endtask

  initial begin
    reset       = 1'b0;
    rx_drv      = 1'b1;
    loop_en     = 1'b0;
    bus.din     = '0;
    bus.wr_en   = 1'b0;
    bus.rdy_clr = 1'b0;
    bus.acc_clr = 1'b0;
    m_rdy       = 1'b0;
    m_dout      = '0;
    m_acc       = '0;

    // Reset held while inputs toggle
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      bus.din     = 8'($urandom);
      bus.wr_en   = 1'($urandom);
      bus.rdy_clr = 1'($urandom);
      bus.acc_clr = 1'($urandom);
    end
    ticks(1);
    chk("rst_tx",   64'(tx),          64'd1);
    chk("rst_busy", 64'(bus.tx_busy), 64'd0);
    chk_rx_state("rst");
    bus.wr_en   = 1'b0;
    bus.rdy_clr = 1'b0;
    bus.acc_clr = 1'b0;
    ticks(1);
    reset = 1'b1;
    ticks(100);
    chk("post_rst_line", 64'({bus.tx_busy, tx}), 64'b01);
    chk_rx_state("post_rst");

    // Transmit 0xA5 with an ignored request mid-frame
    send_tx(8'hA5, 1'b1, "tx_a5");
    chk("tx_a5_no_rx", 64'(bus.rdy), 64'd0);

    // Single receive then handshake clear
    send_rx(8'h3C, 1'b1, 1'b0, 1'b0, "rx_3c");
    clear_rdy("rx_3c");

    // Back-to-back receive into the 16-bit accumulator
    send_rx(8'h01, 1'b1, 1'b0, 1'b0, "b2b_01");
    send_rx(8'h02, 1'b1, 1'b0, 1'b0, "b2b_02");
    send_rx(8'h03, 1'b1, 1'b0, 1'b0, "b2b_03");
    chk("b2b_acc_0203", 64'(bus.acc_data), 64'h0203);
    bus.acc_clr = 1'b1;
    ticks(1);
    bus.acc_clr = 1'b0;
    m_acc = '0;
    chk("acc_clr", 64'(bus.acc_data), 64'(m_acc));

    // Byte completing with rdy_clr keeps rdy; with acc_clr leaves acc empty
    send_rx(8'h5A, 1'b1, 1'b1, 1'b0, "rdyclr_race");
    chk("rdyclr_race_hold", 64'(bus.rdy), 64'd1);
    send_rx(8'hC3, 1'b1, 1'b0, 1'b1, "accclr_race");
    chk("accclr_race_acc", 64'(bus.acc_data), 64'd0);
    clear_rdy("accclr_race");

    // Short low pulse is rejected as a glitch
    rx_drv = 1'b0;
    ticks(100);
    rx_drv = 1'b1;
    ticks(BIT_CYC * 11);
    chk_rx_state("glitch");

    // Framing error leaves outputs untouched
    send_rx(8'h55, 1'b0, 1'b0, 1'b0, "frame_err");

    // Randomized receive frames
    for (int i = 0; i < 2; i++) begin
      rb  = 8'($urandom);
      rs  = ($urandom_range(0, 3) != 0);
      rc0 = 1'($urandom);
      rc1 = 1'($urandom);
      send_rx(rb, rs, rc0, rc1, $sformatf("rnd%0d", i));
    end
    clear_rdy("rnd");

    // Loopback of 0x00, 0xFF and a random byte
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rb = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom);
      send_tx(rb, 1'b0, $sformatf("loop%0d", i));
      m_rdy  = 1'b1;
      m_dout = rb;
      m_acc  = DW'({m_acc, rb});
      chk_rx_state($sformatf("loop%0d", i));
      clear_rdy($sformatf("loop%0d", i));
    end

    // Reset in the middle of a looped-back frame
    bus.din   = 8'hA5;
    bus.wr_en = 1'b1;
    ticks(1);
    bus.wr_en = 1'b0;
    ticks(1000);
    reset = 1'b0;
    #1;
    m_rdy  = 1'b0;
    m_dout = '0;
    m_acc  = '0;
    chk("midrst_tx",   64'(tx),          64'd1);
    chk("midrst_busy", 64'(bus.tx_busy), 64'd0);
    chk_rx_state("midrst");
    ticks(5);
    reset = 1'b1;
    ticks(BIT_CYC * 11);
    chk("midrst_after_line", 64'({bus.tx_busy, tx}), 64'b01);
    chk_rx_state("midrst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
